// File: rtl/mod_shift_pkg.sv
// Shared definitions for the word-serial shift register sequencer.
package mod_shift_pkg;

   // Sequencer state encoding
   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_LOAD   = 3'd1;
   localparam logic [2:0] ST_STREAM = 3'd2;
   localparam logic [2:0] ST_DONE   = 3'd3;
   localparam logic [2:0] ST_ERR    = 3'd4;

   typedef logic [2:0] state_t;

   // Default operand geometry: 64 words of 32 bits (2048-bit register)
   localparam int NWORDS_DEF = 64;
   localparam int WORD_W     = 32;

endpackage

// File: rtl/mod_shift_word_cnt.sv
// Clear/increment up-counter with a terminal-count flag.
// Clear has priority over increment. tc_o is high while the count equals TC.
module mod_shift_word_cnt #(
   parameter int W  = 6,
   parameter int TC = 63
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         clr_i,
   input  logic         inc_i,
   output logic [W-1:0] cnt_o,
   output logic         tc_o
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   // Next count: clear wins, otherwise step by one on increment
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i) begin
         cnt_d = cnt_q + W'(1);
      end
   end

   // Count register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;
   assign tc_o  = (cnt_q == W'(TC));

endmodule

// File: rtl/mod_shift_seq_ctrl.sv
// Sequencer for the word-serial shift register: loads a full-width operand,
// streams it word by word to the word engine, shifts each result word back in,
// and opens the full-width output gate once the last word has been accepted.
//
//  state  | meaning
//  -------+---------------------------------------------------------------
//  IDLE   | waiting for iStart; word acks and result acks ignored
//  LOAD   | one-cycle oLoad pulse, counters cleared
//  STREAM | low word valid to engine; each ack shifts one word
//  DONE   | all words shifted, full-width output gate open until iResultAck
//  ERR    | watchdog expired waiting for an ack; held until iResultAck
module mod_shift_seq_ctrl
   import mod_shift_pkg::*;
#(
   parameter int NWORDS = NWORDS_DEF,
   parameter int CNT_W  = 6,
   parameter int TMO_W  = 10
) (
   input  logic             iClk,
   input  logic             iRst_n,
   input  logic             iStart,
   input  logic             iAbort,
   input  logic             iWordAck,
   input  logic             iResultAck,
   output logic             oLoad,
   output logic             oEnable,
   output logic             oOutputLoad,
   output logic             oWordValid,
   output logic [CNT_W-1:0] oWordIdx,
   output logic             oBusy,
   output logic             oDone,
   output logic             oErr
);

   // Watchdog fires on the idle cycle that would bring the count to all-ones
   localparam int WDOG_TC = (2 ** TMO_W) - 2;

   state_t state_q;
   state_t state_d;

   logic             load_q;
   logic             out_load_q;
   logic             word_valid_q;
   logic             busy_q;
   logic             done_q;
   logic             err_q;

   logic             ack_acc;
   logic             word_clr;
   logic [CNT_W-1:0] word_cnt;
   logic             word_tc;
   logic             wdog_clr;
   logic             wdog_inc;
   logic [TMO_W-1:0] wdog_cnt;
   logic             wdog_tc;

   // An ack only counts in STREAM and never alongside an abort
   assign ack_acc = (state_q == ST_STREAM) && iWordAck && !iAbort;

   // The word count is held at zero whenever the sequencer is not (staying) in
   // STREAM, so it can drive oWordIdx directly and never passes NWORDS-1.
   assign word_clr = (state_q == ST_LOAD) || (state_d != ST_STREAM);

   // Idle cycles in STREAM; saturate instead of wrapping
   assign wdog_clr = iAbort || (state_q == ST_LOAD) || ack_acc;
   assign wdog_inc = (state_q == ST_STREAM) && !iWordAck && !iAbort && (wdog_cnt != '1);

   mod_shift_word_cnt #(
      .W  (CNT_W),
      .TC (NWORDS - 1)
   ) u_word_cnt (
      .clk_i  (iClk),
      .rst_ni (iRst_n),
      .clr_i  (word_clr),
      .inc_i  (ack_acc),
      .cnt_o  (word_cnt),
      .tc_o   (word_tc)
   );

   mod_shift_word_cnt #(
      .W  (TMO_W),
      .TC (WDOG_TC)
   ) u_wdog_cnt (
      .clk_i  (iClk),
      .rst_ni (iRst_n),
      .clr_i  (wdog_clr),
      .inc_i  (wdog_inc),
      .cnt_o  (wdog_cnt),
      .tc_o   (wdog_tc)
   );

   // Next-state logic; abort overrides everything
   always_comb begin
      state_d = state_q;
      if (iAbort) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (iStart) state_d = ST_LOAD;
            end
            ST_LOAD: begin
               state_d = ST_STREAM;
            end
            ST_STREAM: begin
               if (ack_acc) begin
                  if (word_tc) state_d = ST_DONE;
               end else if (wdog_inc && wdog_tc) begin
                  state_d = ST_ERR;
               end
            end
            ST_DONE, ST_ERR: begin
               if (iResultAck) state_d = ST_IDLE;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   // State register and registered output decode from the next state
   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         state_q      <= ST_IDLE;
         load_q       <= 1'b0;
         out_load_q   <= 1'b0;
         word_valid_q <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         load_q       <= (state_d == ST_LOAD);
         out_load_q   <= (state_d == ST_DONE);
         word_valid_q <= (state_d == ST_STREAM);
         busy_q       <= (state_d == ST_LOAD) || (state_d == ST_STREAM);
         done_q       <= (state_d == ST_DONE);
         err_q        <= (state_d == ST_ERR);
      end
   end

   // Shift pulse lands on the same edge that accepts the ack
   assign oEnable     = ack_acc;
   assign oLoad       = load_q;
   assign oOutputLoad = out_load_q;
   assign oWordValid  = word_valid_q;
   assign oWordIdx    = word_cnt;
   assign oBusy       = busy_q;
   assign oDone       = done_q;
   assign oErr        = err_q;

endmodule
